conv_encoder_stream: RTL

//  Frame-based streaming convolutional encoder, successor of the per-bit encode path: runtime K (3/5/7/9), rate 1/2 or 1/3.

---
 rtl/conv_enc_pkg.sv | 45 ++++
 rtl/conv_encoder_stream_if.sv | 22 ++
 rtl/conv_encoder_stream_core.sv | 40 ++++
 rtl/conv_encoder_stream.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared constants, state encoding and codeword helpers for the streaming convolutional encoder.
package conv_enc_pkg;
  localparam int MAX_CONSTRAINT_LENGTH = 9;
  localparam int MAX_CODE_RATE         = 3;
  localparam logic DECODE_MODE = 1'b1;
  localparam logic ENCODE_MODE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    TAIL   = 2'd2,
    DONE   = 2'd3
  } enc_state_t;

  typedef logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0] poly_set_t;

  // 00:K=3 01:K=5 10:K=7 11:K=9
  function automatic logic [3:0] k_from_sel(input logic [1:0] sel);
    return 4'd3 + {1'b0, sel, 1'b0};
  endfunction

  function automatic logic [MAX_CONSTRAINT_LENGTH-1:0] k_mask(input logic [1:0] sel);
    logic [MAX_CONSTRAINT_LENGTH-1:0] mask;
    case (sel)
      2'b00:   mask = 9'h007;
      2'b01:   mask = 9'h01f;
      2'b10:   mask = 9'h07f;
      default: mask = 9'h1ff;
    endcase
    return mask;
  endfunction

  function automatic logic [MAX_CODE_RATE-1:0] conv_encode(
    input poly_set_t                        polys,
    input logic [MAX_CONSTRAINT_LENGTH-1:0] win,
    input logic [MAX_CONSTRAINT_LENGTH-1:0] mask
  );
    logic [MAX_CODE_RATE-1:0] code;
    code = '0;
    for (int i = 0; i < MAX_CODE_RATE; i++) begin
      code[i] = ^(polys[i] & win & mask);
    end
    return code;
  endfunction
endpackage

// File: rtl/conv_encoder_stream_if.sv
// Bit-in / codeword-out streaming handshake of conv_encoder_stream.
interface conv_encoder_stream_if #(
  parameter int MAX_RATE = 3
);
  logic                i_bit;
  logic                i_bit_valid;
  logic                o_bit_ready;
  logic [MAX_RATE-1:0] o_enc_data;
  logic                o_enc_valid;
  logic                i_enc_ready;
  logic                o_enc_last;

  modport slave (
    input  i_bit, i_bit_valid, i_enc_ready,
    output o_bit_ready, o_enc_data, o_enc_valid, o_enc_last
  );

  modport master (
    output i_bit, i_bit_valid, i_enc_ready,
    input  o_bit_ready, o_enc_data, o_enc_valid, o_enc_last
  );
endinterface

// File: rtl/conv_encoder_stream_core.sv
// Encoder shift register and codeword generation; shifts on each accepted beat, clears on frame start.
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_ce,
  input  logic                     i_clear,
  input  logic                     i_shift,
  input  logic                     i_bit,
  input  logic [1:0]               i_k_sel,
  input  logic                     i_rate,
  input  poly_set_t                i_polys,
  output logic [MAX_CODE_RATE-1:0] o_code
);
  logic [MAX_CONSTRAINT_LENGTH-2:0] r_sr;
  logic [MAX_CONSTRAINT_LENGTH-1:0] w_win;
  logic [MAX_CODE_RATE-1:0]         w_code;

  // r_sr[0] holds the bit delayed by one; bits beyond K-1 are masked off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (en_ce) begin
      if (i_clear) begin
        r_sr <= '0;
      end else if (i_shift) begin
        r_sr <= {r_sr[MAX_CONSTRAINT_LENGTH-3:0], i_bit};
      end
    end
  end

  assign w_win  = {r_sr, i_bit};
  assign w_code = conv_encode(i_polys, w_win, k_mask(i_k_sel));

  always_comb begin
    o_code = w_code;
    if (!i_rate) o_code[MAX_CODE_RATE-1] = 1'b0;
  end
endmodule

// File: rtl/conv_encoder_stream.sv
// Frame-based streaming convolutional encoder, runtime K 3/5/7/9, rate 1/2 or 1/3, one codeword per bit.
// Macro CONV_ENC_TAIL_EN appends K-1 zero tail codewords so the trellis terminates in state 0.
module conv_encoder_stream
  import conv_enc_pkg::*;
#(
  parameter int MAX_K       = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_RATE    = MAX_CODE_RATE,
  parameter int FRAME_LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_ce,
  input  logic                   i_start,
  input  logic                   i_code_rate,
  input  logic [1:0]             i_constr_len,
  input  logic [MAX_K-1:0]       i_gen_poly [MAX_RATE-1:0],
  input  logic [FRAME_LEN_W-1:0] i_frame_len,
  conv_encoder_stream_if.slave   strm,
  output logic                   o_encoder_done
);
`ifdef CONV_ENC_TAIL_EN
  localparam logic TAIL_EN = 1'b1;
`else
  localparam logic TAIL_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ENCODE = ENCODE;
  localparam logic [1:0] ST_TAIL   = TAIL;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]             r_state;
  logic                   r_rate;
  logic [1:0]             r_k_sel;
  poly_set_t              r_polys;
  logic [FRAME_LEN_W-1:0] r_frame_len;
  logic [FRAME_LEN_W-1:0] r_bit_cnt;
  logic [3:0]             r_tail_cnt;
  logic [MAX_RATE-1:0]    r_enc_data;
  logic                   r_enc_valid;
  logic                   r_enc_last;
  logic                   r_done;

  poly_set_t              w_poly_in;
  logic [MAX_RATE-1:0]    w_code;
  logic                   w_out_free, w_bit_ready, w_beat, w_tail_beat, w_shift, w_start;
  logic                   w_data_end, w_tail_end, w_enc_bit;
  logic [FRAME_LEN_W-1:0] w_bit_cnt_nxt;
  logic [3:0]             w_tail_cnt_nxt, w_tail_len;

  always_comb begin
    w_poly_in = '0;
    for (int i = 0; i < MAX_RATE; i++) w_poly_in[i] = i_gen_poly[i];
  end

  assign w_out_free     = !r_enc_valid || strm.i_enc_ready;
  assign w_bit_ready    = en_ce && (r_state == ST_ENCODE) && w_out_free;
  assign w_beat         = strm.i_bit_valid && w_bit_ready;
  assign w_tail_beat    = en_ce && (r_state == ST_TAIL) && w_out_free;
  assign w_shift        = w_beat || w_tail_beat;
  assign w_start        = en_ce && i_start && (r_state == ST_IDLE);
  assign w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
  assign w_data_end     = (w_bit_cnt_nxt == r_frame_len);
  assign w_tail_len     = k_from_sel(r_k_sel) - 4'd1;
  assign w_tail_cnt_nxt = r_tail_cnt + 4'd1;
  assign w_tail_end     = (w_tail_cnt_nxt == w_tail_len);
  assign w_enc_bit      = (r_state == ST_ENCODE) && strm.i_bit;

  conv_enc_core u_core (
    .clk     (clk),
    .rst     (rst),
    .en_ce   (en_ce),
    .i_clear (w_start),
    .i_shift (w_shift),
    .i_bit   (w_enc_bit),
    .i_k_sel (r_k_sel),
    .i_rate  (r_rate),
    .i_polys (r_polys),
    .o_code  (w_code)
  );

  // IDLE wait start | ENCODE take bits | TAIL zero flush | DONE drain last word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rate      <= 1'b0;
      r_k_sel     <= 2'b00;
      r_polys     <= '0;
      r_frame_len <= '0;
      r_bit_cnt   <= '0;
      r_tail_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en_ce) begin
        case (r_state)
          ST_IDLE: if (i_start) begin
            r_rate      <= i_code_rate;
            r_k_sel     <= i_constr_len;
            r_polys     <= w_poly_in;
            r_frame_len <= i_frame_len;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= '0;
            if (i_frame_len != '0) r_state <= ST_ENCODE;
            else                   r_state <= TAIL_EN ? ST_TAIL : ST_DONE;
          end
          ST_ENCODE: if (w_beat) begin
            r_bit_cnt <= w_bit_cnt_nxt;
            if (w_data_end) r_state <= TAIL_EN ? ST_TAIL : ST_DONE;
          end
          ST_TAIL: if (w_tail_beat) begin
            r_tail_cnt <= w_tail_cnt_nxt;
            if (w_tail_end) r_state <= ST_DONE;
          end
          default: if (w_out_free) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Acceptance retires the word even while en_ce is low, so nothing is duplicated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enc_data  <= '0;
      r_enc_valid <= 1'b0;
      r_enc_last  <= 1'b0;
    end else if (w_shift) begin
      r_enc_data  <= w_code;
      r_enc_valid <= 1'b1;
      r_enc_last  <= (w_beat && w_data_end && !TAIL_EN) || (w_tail_beat && w_tail_end);
    end else if (strm.i_enc_ready) begin
      r_enc_valid <= 1'b0;
      r_enc_last  <= 1'b0;
    end
  end

  assign strm.o_bit_ready = w_bit_ready;
  assign strm.o_enc_data  = r_enc_data;
  assign strm.o_enc_valid = r_enc_valid;
  assign strm.o_enc_last  = r_enc_last;
  assign o_encoder_done   = r_done;
endmodule
